// File: rtl/tetris_move_sched_if.sv
// Command handshake between the move scheduler and the game core.
// master = scheduler (issues commands), slave = core (accepts them).
interface tetris_move_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/tetris_move_sched.sv
// Input and gravity scheduler for the tetris core: merges button edges,
// horizontal auto-repeat and the gravity timer into a single stream of
// move commands, one in flight at a time.
module tetris_move_sched #(
  parameter int unsigned GRAV_PERIOD  = 50000000,
  parameter int unsigned GRAV_STEP    = 3000000,
  parameter int unsigned GRAV_MIN     = 5000000,
  parameter int unsigned REPEAT_DELAY = 20000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned CW           = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic                       Left,
  input  logic                       Right,
  input  logic                       Rot,
  input  logic                       Drop,
  input  logic [3:0]                 Level,
  input  logic                       Landed,
  tetris_move_sched_if.master        cmd,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_ROT   = 3'd3,
    OP_DOWN  = 3'd4,
    OP_DROP  = 3'd5
  } op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d, win;
  logic          valid_q, valid_d;
  logic [CW-1:0] grav_q, grav_d, grav_next;
  logic [CW-1:0] rep_l_q, rep_l_d, rep_l_n;
  logic [CW-1:0] rep_r_q, rep_r_d, rep_r_n;
  logic          pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic          pend_rot_q, pend_rot_d, pend_drop_q, pend_drop_d;
  logic          pend_down_q, pend_down_d;
  logic [2:0]    starve_q, starve_d;
  logic          left_q, right_q, rot_q, drop_q;

  logic [CW-1:0] prod, period, per_m1;
  logic          conflict, grav_hit, fire_l, fire_r, edge_rot, edge_drop;

  // Effective gravity period for the current level, floored at GRAV_MIN.
  always_comb begin
    prod = {{(CW-4){1'b0}}, Level} * CW'(GRAV_STEP);
    if (prod >= CW'(GRAV_PERIOD))
      period = CW'(GRAV_MIN);
    else if ((CW'(GRAV_PERIOD) - prod) < CW'(GRAV_MIN))
      period = CW'(GRAV_MIN);
    else
      period = CW'(GRAV_PERIOD) - prod;
    per_m1 = period - CW'(1);
  end

  // Event sources: gravity wrap, button edges and Left/Right auto-repeat.
  // The repeat counters count down; reaching 1 fires and reloads REPEAT_RATE,
  // 0 means disarmed (after a Left+Right conflict until re-press).
  always_comb begin
    conflict  = Left & Right;
    grav_hit  = (grav_q >= per_m1);
    grav_next = grav_hit ? '0 : grav_q + CW'(1);
    edge_rot  = Rot & ~rot_q;
    edge_drop = Drop & ~drop_q;

    fire_l  = 1'b0;
    rep_l_n = '0;
    if (Left && !conflict) begin
      if (!left_q) begin
        fire_l  = 1'b1;
        rep_l_n = CW'(REPEAT_DELAY);
      end else if (rep_l_q == CW'(1)) begin
        fire_l  = 1'b1;
        rep_l_n = CW'(REPEAT_RATE);
      end else if (rep_l_q != '0) begin
        rep_l_n = rep_l_q - CW'(1);
      end
    end

    fire_r  = 1'b0;
    rep_r_n = '0;
    if (Right && !conflict) begin
      if (!right_q) begin
        fire_r  = 1'b1;
        rep_r_n = CW'(REPEAT_DELAY);
      end else if (rep_r_q == CW'(1)) begin
        fire_r  = 1'b1;
        rep_r_n = CW'(REPEAT_RATE);
      end else if (rep_r_q != '0) begin
        rep_r_n = rep_r_q - CW'(1);
      end
    end
  end

  // Fixed-priority arbitration with the gravity anti-starvation override.
  always_comb begin
    win = OP_NONE;
    if (pend_down_q && (starve_q >= 3'd4)) win = OP_DOWN;
    else if (pend_drop_q)                  win = OP_DROP;
    else if (pend_rot_q)                   win = OP_ROT;
    else if (pend_l_q)                     win = OP_LEFT;
    else if (pend_r_q)                     win = OP_RIGHT;
    else if (pend_down_q)                  win = OP_DOWN;
  end

  // Next-state: issue/handshake FSM, then pend-flag merge and Landed override.
  // The winner's flag is cleared before new events are ORed in, so an event
  // of the same kind arriving in the issue cycle is kept for the next issue.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    op_d        = op_q;
    grav_d      = grav_next;
    rep_l_d     = rep_l_n;
    rep_r_d     = rep_r_n;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_rot_d  = pend_rot_q;
    pend_drop_d = pend_drop_q;
    pend_down_d = pend_down_q;
    starve_d    = starve_q;

    case (state_q)
      S_RUN: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else if (win != OP_NONE) begin
          state_d = S_WAIT;
          valid_d = 1'b1;
          op_d    = win;
          case (win)
            OP_LEFT:  pend_l_d    = 1'b0;
            OP_RIGHT: pend_r_d    = 1'b0;
            OP_ROT:   pend_rot_d  = 1'b0;
            OP_DROP:  pend_drop_d = 1'b0;
            OP_DOWN:  pend_down_d = 1'b0;
            default:  ;
          endcase
          if (win == OP_DOWN || !pend_down_q) starve_d = '0;
          else                                starve_d = starve_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (valid_q && cmd.cmd_ready) begin
          valid_d = 1'b0;
          op_d    = OP_NONE;
          state_d = Enable ? S_RUN : S_IDLE;
        end
      end
      default: begin
        if (Enable) state_d = S_RUN;
      end
    endcase

    if (state_q == S_IDLE) begin
      grav_d      = '0;
      rep_l_d     = '0;
      rep_r_d     = '0;
      pend_l_d    = 1'b0;
      pend_r_d    = 1'b0;
      pend_rot_d  = 1'b0;
      pend_drop_d = 1'b0;
      pend_down_d = 1'b0;
      starve_d    = '0;
      valid_d     = 1'b0;
      op_d        = OP_NONE;
    end else begin
      pend_l_d    = pend_l_d    | fire_l;
      pend_r_d    = pend_r_d    | fire_r;
      pend_rot_d  = pend_rot_d  | edge_rot;
      pend_drop_d = pend_drop_d | edge_drop;
      pend_down_d = pend_down_d | grav_hit;
      if (Landed) begin
        grav_d      = '0;
        pend_down_d = 1'b0;
        pend_drop_d = 1'b0;
        starve_d    = '0;
      end
    end
  end

  // State, counters, pend flags and button edge registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      op_q        <= OP_NONE;
      grav_q      <= '0;
      rep_l_q     <= '0;
      rep_r_q     <= '0;
      pend_l_q    <= 1'b0;
      pend_r_q    <= 1'b0;
      pend_rot_q  <= 1'b0;
      pend_drop_q <= 1'b0;
      pend_down_q <= 1'b0;
      starve_q    <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      rot_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      op_q        <= op_d;
      grav_q      <= grav_d;
      rep_l_q     <= rep_l_d;
      rep_r_q     <= rep_r_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_rot_q  <= pend_rot_d;
      pend_drop_q <= pend_drop_d;
      pend_down_q <= pend_down_d;
      starve_q    <= starve_d;
      left_q      <= Left;
      right_q     <= Right;
      rot_q       <= Rot;
      drop_q      <= Drop;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_op    = op_q;
  assign busy          = (state_q == S_WAIT);

endmodule

// File: tb/tb_tetris_move_sched.sv
// Bench for tetris_move_sched: directed scenarios with hand-computed
// expectations plus a long randomized run, all compared cycle by cycle
// against a time-based behavioural model of the scheduler.
module tb_tetris_move_sched;

  localparam int GP = 20;
  localparam int GS = 4;
  localparam int GM = 4;
  localparam int RD = 6;
  localparam int RR = 3;

  logic       Clk;
  logic       Reset;
  logic       Enable;
  logic       Left, Right, Rot, Drop, Landed;
  logic [3:0] Level;
  logic       busy;

  tetris_move_sched_if cif();

  tetris_move_sched #(
    .GRAV_PERIOD (GP),
    .GRAV_STEP   (GS),
    .GRAV_MIN    (GM),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CW          (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Enable(Enable),
    .Left  (Left),
    .Right (Right),
    .Rot   (Rot),
    .Drop  (Drop),
    .Level (Level),
    .Landed(Landed),
    .cmd   (cif),
    .busy  (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests;
  int n_fail;

  // ---------------- behavioural model ----------------
  // Gravity is tracked as the cycle at which the count last restarted, and
  // auto-repeat as the cycle at which the current press began.
  bit         m_on;        // scheduler enabled (not idle)
  bit         m_inflight;  // a command is on the bus
  logic [2:0] m_op;
  bit         m_pend [6];  // indexed by command code
  int         m_starve;
  int         m_gorg;
  int         m_lst, m_rst;
  bit         m_pl, m_pr, m_prot, m_pdrop;
  int         cyc;

  function automatic int eff_period(input int lvl);
    int prod;
    prod = lvl * GS;
    if (prod >= GP) return GM;
    return (GP - prod > GM) ? GP - prod : GM;
  endfunction

  function automatic bit rep_fire(input int held);
    if (held == RD) return 1'b1;
    if (held > RD && ((held - RD) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    int order [5];
    order = '{5, 3, 1, 2, 4};
    if (m_pend[4] && m_starve >= 4) return 4;
    for (int k = 0; k < 5; k++)
      if (m_pend[order[k]]) return order[k];
    return 0;
  endfunction

  task automatic model_reset();
    m_on = 0; m_inflight = 0; m_op = 3'd0;
    for (int i = 0; i < 6; i++) m_pend[i] = 0;
    m_starve = 0; m_gorg = 0; m_lst = -1; m_rst = -1;
    m_pl = 0; m_pr = 0; m_prot = 0; m_pdrop = 0;
  endtask

  task automatic model_step();
    bit set [6];
    bit was_on, confl, any, down_was;
    int w;
    for (int i = 0; i < 6; i++) set[i] = 0;
    was_on = m_on;
    confl  = Left && Right;

    if (was_on && (cyc - m_gorg) >= eff_period(int'(Level)) - 1) begin
      set[4] = 1;
      m_gorg = cyc + 1;
    end

    if (!was_on || confl || !Left) m_lst = -1;
    else if (!m_pl) begin m_lst = cyc; set[1] = 1; end
    else if (m_lst >= 0 && rep_fire(cyc - m_lst)) set[1] = 1;

    if (!was_on || confl || !Right) m_rst = -1;
    else if (!m_pr) begin m_rst = cyc; set[2] = 1; end
    else if (m_rst >= 0 && rep_fire(cyc - m_rst)) set[2] = 1;

    if (was_on && Rot && !m_prot)   set[3] = 1;
    if (was_on && Drop && !m_pdrop) set[5] = 1;
    m_pl = Left; m_pr = Right; m_prot = Rot; m_pdrop = Drop;

    if (!was_on) begin
      for (int i = 0; i < 6; i++) m_pend[i] = 0;
      m_starve = 0; m_inflight = 0; m_op = 3'd0;
      m_gorg = cyc + 1;
      if (Enable) m_on = 1;
    end else if (!m_inflight) begin
      any = 0;
      for (int i = 1; i < 6; i++) any = any | m_pend[i];
      if (!Enable) m_on = 0;
      else if (any) begin
        w = pick();
        down_was = m_pend[4];
        m_pend[w] = 0;
        if (w == 4 || !down_was) m_starve = 0;
        else m_starve = m_starve + 1;
        m_inflight = 1;
        m_op = 3'(w);
      end
    end else if (cif.cmd_ready) begin
      m_inflight = 0; m_op = 3'd0;
      if (!Enable) m_on = 0;
    end

    if (was_on) begin
      for (int i = 0; i < 6; i++) m_pend[i] = m_pend[i] | set[i];
      if (Landed) begin
        m_pend[4] = 0; m_pend[5] = 0; m_starve = 0; m_gorg = cyc + 1;
      end
    end
    cyc = cyc + 1;
  endtask

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) model_reset();
    else        model_step();
  end

  initial cyc = 0;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare {valid, op, busy} against the model.
  task automatic step();
    @(posedge Clk);
    #1;
    check("model_cmp", int'({cif.cmd_valid, cif.cmd_op, busy}),
          int'({m_inflight, m_op, m_inflight}));
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cif.cmd_valid && n < maxc);
    check("wait_valid_seen", int'(cif.cmd_valid), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, cnt, bad;
    n_tests = 0; n_fail = 0;
    Reset = 0; Enable = 1; Left = 0; Right = 0; Rot = 0; Drop = 0;
    Landed = 0; Level = 4'd0; cif.cmd_ready = 1;

    // Reset state
    step(); step();
    check("reset_valid", int'(cif.cmd_valid), 0);
    check("reset_op",    int'(cif.cmd_op), 0);
    check("reset_busy",  int'(busy), 0);
    Reset = 1;

    // Gravity at level 0: first DOWN 21 cycles after entering RUN, period 20
    step();
    n = 0;
    do begin step(); n++; end while (!cif.cmd_valid && n < 40);
    check("first_down_latency", n, 21);
    check("first_down_op", int'(cif.cmd_op), 4);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cif.cmd_valid && cif.cmd_op == 3'd4) cnt++;
    end
    check("down_count_100", cnt, 5);

    // Level 5 saturates to GRAV_MIN = 4
    Level = 4'd5;
    wait_valid(30, n);
    wait_valid(10, n);
    wait_valid(10, n);
    check("level5_period", n, 4);
    check("level5_op", int'(cif.cmd_op), 4);
    Level = 4'd0;

    // Left held 15 cycles: edge + t+6, t+9, t+12
    Left = 1; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cif.cmd_valid && cif.cmd_op == 3'd1) cnt++;
    end
    Left = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cif.cmd_valid && cif.cmd_op == 3'd1) cnt++;
    end
    check("left_repeat_count", cnt, 4);

    // Left+Right together: no horizontal command at all
    Left = 1; Right = 1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cif.cmd_valid && cif.cmd_op != 3'd4) bad++;
    end
    Left = 0; Right = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cif.cmd_valid && cif.cmd_op != 3'd4) bad++;
    end
    check("left_right_conflict", bad, 0);

    // Rot+Drop together with cmd_ready low
    Enable = 0;
    step(); step(); step();
    check("idle_before_rotdrop", int'({cif.cmd_valid, busy}), 0);
    Enable = 1; cif.cmd_ready = 0;
    step(); step();
    Rot = 1; Drop = 1;
    wait_valid(6, n);
    check("hard_drop_first", int'(cif.cmd_op), 5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hard_drop_held", int'({cif.cmd_valid, cif.cmd_op, busy}), 5'b1_101_1);
    end
    cif.cmd_ready = 1;
    step();
    check("hard_drop_acked", int'(cif.cmd_valid), 0);
    cif.cmd_ready = 0;
    wait_valid(6, n);
    check("rot_after_drop", int'(cif.cmd_op), 3);
    #2 Reset = 0;
    #1;
    check("async_reset_valid", int'(cif.cmd_valid), 0);
    check("async_reset_busy",  int'(busy), 0);
    Rot = 0; Drop = 0; cif.cmd_ready = 1;
    step(); step();
    Reset = 1;

    // Landed coinciding with the gravity wrap suppresses that DOWN
    wait_valid(40, n);
    check("pre_landed_down", int'(cif.cmd_op), 4);
    for (int i = 0; i < 18; i++) step();
    Landed = 1;
    step();
    Landed = 0;
    wait_valid(40, n);
    check("landed_next_down_gap", n, 21);
    check("landed_next_op", int'(cif.cmd_op), 4);

    // Enable dropped while the command waits for ready
    cif.cmd_ready = 0;
    wait_valid(30, n);
    Enable = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("enable_drop_held", int'({cif.cmd_valid, busy}), 2'b11);
    end
    cif.cmd_ready = 1;
    step();
    check("enable_drop_release", int'({cif.cmd_valid, busy}), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cif.cmd_valid) cnt++;
    end
    check("idle_no_commands", cnt, 0);
    Enable = 1;

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) Left  = ~Left;
      if ($urandom_range(0, 15) == 0) Right = ~Right;
      if ($urandom_range(0, 9) == 0)  Rot   = ~Rot;
      if ($urandom_range(0, 9) == 0)  Drop  = ~Drop;
      Landed        = ($urandom_range(0, 39) == 0);
      cif.cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) Level = 4'($urandom_range(0, 15));
      if (Enable) begin
        if ($urandom_range(0, 149) == 0) Enable = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        Enable = 1;
      end
      Reset = !(i > 0 && $urandom_range(0, 999) == 0);
      step();
    end
    Reset = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
